// File: rtl/mac_rx_xgmii_dec.sv
// RX control decoder for a 2-lane XGMII-style word stream, producing the mac_*
// framing interface consumed by eth_rx.
//  state | meaning
//  IDLE  | between frames, waiting for S on lane 0
//  FRAME | inside a frame, counting data bytes against MAX_LEN
//  DROP  | frame aborted, discarding words until T or an idle word
module mac_rx_xgmii_dec #(
  parameter int DATA_W      = 16,
  parameter int KEEP_W      = DATA_W / 8,
  parameter int LANE0_CNT_N = 1,
  parameter int MAX_LEN     = 1518,
  parameter int ERR_CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   nreset,
  input  logic                   xgmii_valid_i,
  input  logic [DATA_W-1:0]      xgmii_data_i,
  input  logic [KEEP_W-1:0]      xgmii_ctrl_i,
  output logic                   mac_valid_o,
  output logic                   mac_cancel_o,
  output logic [DATA_W-1:0]      mac_data_o,
  output logic                   mac_ctrl_v_o,
  output logic                   mac_idle_o,
  output logic [LANE0_CNT_N-1:0] mac_start_o,
  output logic                   mac_term_o,
  output logic [KEEP_W-1:0]      mac_term_keep_o,
  output logic [ERR_CNT_W-1:0]   err_cnt_o
);

  localparam logic [7:0]             CH_S      = 8'hFB;
  localparam logic [7:0]             CH_T      = 8'hFD;
  localparam logic [7:0]             CH_I      = 8'h07;
  localparam logic [16:0]            MAX_LEN_W = 17'(MAX_LEN);
  localparam logic [LANE0_CNT_N-1:0] START_ONE = LANE0_CNT_N'(1);
  localparam logic [KEEP_W-1:0]      KEEP_L0   = KEEP_W'(1);
  localparam logic [ERR_CNT_W-1:0]   ERR_ONE   = ERR_CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FRAME = 2'd1,
    ST_DROP  = 2'd2
  } state_t;

  state_t        state;
  logic [15:0]   len_cnt;

  logic [7:0]    lane0;
  logic [7:0]    lane1;
  logic          ctl0;
  logic          ctl1;
  logic          s0;
  logic          t0;
  logic          t1;
  logic          i0;
  logic          i1;
  logic          both_idle;
  logic          any_ctrl;
  logic          any_t;
  logic          data_only;
  logic          term0_ok;
  logic          term1_ok;
  logic [16:0]   len_p1;
  logic [16:0]   len_p2;
  logic          over_p1;
  logic          over_p2;
  logic [ERR_CNT_W-1:0] err_next;

  assign lane0 = xgmii_data_i[7:0];
  assign lane1 = xgmii_data_i[15:8];
  assign ctl0  = xgmii_ctrl_i[0];
  assign ctl1  = xgmii_ctrl_i[1];

  assign s0 = ctl0 && (lane0 == CH_S);
  assign t0 = ctl0 && (lane0 == CH_T);
  assign t1 = ctl1 && (lane1 == CH_T);
  assign i0 = ctl0 && (lane0 == CH_I);
  assign i1 = ctl1 && (lane1 == CH_I);

  assign both_idle = i0 && i1;
  assign any_ctrl  = |xgmii_ctrl_i;
  assign any_t     = t0 || t1;
  assign data_only = !any_ctrl;

  // T on lane 0 may be followed by idle or plain data on lane 1; anything else aborts.
  assign term0_ok = t0 && (!ctl1 || i1);
  assign term1_ok = !ctl0 && t1;

  // One extra bit so the length check sees the overflow before the counter wraps.
  assign len_p1  = {1'b0, len_cnt} + 17'd1;
  assign len_p2  = {1'b0, len_cnt} + 17'd2;
  assign over_p1 = len_p1 > MAX_LEN_W;
  assign over_p2 = len_p2 > MAX_LEN_W;

  assign err_next = (&err_cnt_o) ? err_cnt_o : err_cnt_o + ERR_ONE;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state           <= ST_IDLE;
      len_cnt         <= '0;
      err_cnt_o       <= '0;
      mac_valid_o     <= 1'b0;
      mac_cancel_o    <= 1'b0;
      mac_data_o      <= '0;
      mac_ctrl_v_o    <= 1'b0;
      mac_idle_o      <= 1'b0;
      mac_start_o     <= '0;
      mac_term_o      <= 1'b0;
      mac_term_keep_o <= '0;
    end else begin
      mac_valid_o     <= xgmii_valid_i;
      mac_ctrl_v_o    <= xgmii_valid_i && any_ctrl;
      mac_cancel_o    <= 1'b0;
      mac_idle_o      <= 1'b0;
      mac_start_o     <= '0;
      mac_term_o      <= 1'b0;
      mac_term_keep_o <= '0;

      if (xgmii_valid_i) begin
        mac_data_o <= xgmii_data_i;
        case (state)
          ST_IDLE: begin
            if (s0) begin
              mac_start_o <= START_ONE;
              len_cnt     <= 16'd1;
              state       <= ST_FRAME;
            end else if (both_idle) begin
              mac_idle_o <= 1'b1;
            end else if (any_ctrl) begin
              err_cnt_o <= err_next;
            end
          end

          ST_FRAME: begin
            if (data_only && !over_p2) begin
              len_cnt <= len_p2[15:0];
            end else if (term0_ok) begin
              mac_term_o      <= 1'b1;
              mac_term_keep_o <= '0;
              len_cnt         <= '0;
              state           <= ST_IDLE;
            end else if (term1_ok && !over_p1) begin
              mac_term_o      <= 1'b1;
              mac_term_keep_o <= KEEP_L0;
              len_cnt         <= len_p1[15:0];
              state           <= ST_IDLE;
            end else begin
              // Bad control character or length overflow; also wins over a terminate.
              mac_cancel_o <= 1'b1;
              err_cnt_o    <= err_next;
              len_cnt      <= '0;
              state        <= ST_DROP;
            end
          end

          ST_DROP: begin
            if (any_t || both_idle) begin
              state <= ST_IDLE;
            end
          end

          default: begin
            state   <= ST_IDLE;
            len_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mac_rx_xgmii_dec.sv
// Scoreboard bench for mac_rx_xgmii_dec: a word-level reference model queues the
// expected mac_* word per input cycle; a monitor pops and compares one cycle later.
module tb_mac_rx_xgmii_dec;
  localparam int MAXL = 64;

  logic        clk = 1'b0;
  logic        nreset;
  logic        xgmii_valid_i;
  logic [15:0] xgmii_data_i;
  logic [1:0]  xgmii_ctrl_i;
  logic        mac_valid_o;
  logic        mac_cancel_o;
  logic [15:0] mac_data_o;
  logic        mac_ctrl_v_o;
  logic        mac_idle_o;
  logic [0:0]  mac_start_o;
  logic        mac_term_o;
  logic [1:0]  mac_term_keep_o;
  logic [15:0] err_cnt_o;

  always #5 clk = ~clk;

  mac_rx_xgmii_dec #(
    .DATA_W(16), .KEEP_W(2), .LANE0_CNT_N(1), .MAX_LEN(MAXL), .ERR_CNT_W(16)
  ) dut (
    .clk(clk), .nreset(nreset),
    .xgmii_valid_i(xgmii_valid_i), .xgmii_data_i(xgmii_data_i), .xgmii_ctrl_i(xgmii_ctrl_i),
    .mac_valid_o(mac_valid_o), .mac_cancel_o(mac_cancel_o), .mac_data_o(mac_data_o),
    .mac_ctrl_v_o(mac_ctrl_v_o), .mac_idle_o(mac_idle_o), .mac_start_o(mac_start_o),
    .mac_term_o(mac_term_o), .mac_term_keep_o(mac_term_keep_o), .err_cnt_o(err_cnt_o)
  );

  typedef struct {
    logic        valid;
    logic        cancel;
    logic        start;
    logic        term;
    logic        idle;
    logic        ctrl_v;
    logic [1:0]  keep;
    logic [15:0] data;
    int          err;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model state: where we are in the frame stream, bytes so far, errors.
  bit m_in_frame;
  bit m_dropping;
  int m_len;
  int m_err;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model(input logic v, input logic [15:0] d, input logic [1:0] c, output exp_t e);
    bit [7:0] b0;
    bit [7:0] b1;
    bit start0, term0, term1, idle0, idle1, ends, ok;
    int add;
    b0 = d[7:0];
    b1 = d[15:8];
    start0 = c[0] && b0 == 8'hFB;
    term0  = c[0] && b0 == 8'hFD;
    term1  = c[1] && b1 == 8'hFD;
    idle0  = c[0] && b0 == 8'h07;
    idle1  = c[1] && b1 == 8'h07;
    e.valid  = v;
    e.cancel = 1'b0;
    e.start  = 1'b0;
    e.term   = 1'b0;
    e.idle   = 1'b0;
    e.keep   = 2'b00;
    e.data   = d;
    e.ctrl_v = v && (c != 2'b00);
    if (v) begin
      if (m_in_frame) begin
        ok = 1'b1; ends = 1'b0; add = 0;
        if (c == 2'b00) add = 2;
        else if (term0 && (!c[1] || idle1)) begin ends = 1'b1; e.keep = 2'b00; end
        else if (!c[0] && term1) begin ends = 1'b1; add = 1; e.keep = 2'b01; end
        else ok = 1'b0;
        if (!ok || m_len + add > MAXL) begin
          e.cancel = 1'b1;
          e.keep = 2'b00;
          if (m_err < 65535) m_err++;
          m_in_frame = 1'b0;
          m_dropping = 1'b1;
        end else begin
          m_len += add;
          if (ends) begin
            e.term = 1'b1;
            m_in_frame = 1'b0;
          end
        end
      end else if (m_dropping) begin
        if (term0 || term1 || (idle0 && idle1)) m_dropping = 1'b0;
      end else begin
        if (start0) begin
          e.start = 1'b1;
          m_in_frame = 1'b1;
          m_len = 1;
        end else if (idle0 && idle1) e.idle = 1'b1;
        else if (c != 2'b00 && m_err < 65535) m_err++;
      end
    end
    e.err = m_err;
  endtask

  task automatic model_reset();
    m_in_frame = 1'b0;
    m_dropping = 1'b0;
    m_len = 0;
    m_err = 0;
  endtask

  task automatic send(input logic v, input logic [15:0] d, input logic [1:0] c);
    exp_t e;
    @(negedge clk);
    xgmii_valid_i = v;
    xgmii_data_i  = d;
    xgmii_ctrl_i  = c;
    model(v, d, c, e);
    exp_q.push_back(e);
  endtask

  function automatic logic [15:0] rnd16();
    return 16'($urandom_range(0, 65535));
  endfunction

  task automatic idle_w();                     send(1'b1, 16'h0707, 2'b11);      endtask
  task automatic start_w(input logic [7:0] b); send(1'b1, {b, 8'hFB}, 2'b01);    endtask
  task automatic data_w();                     send(1'b1, rnd16(), 2'b00);       endtask
  task automatic term0_w();                    send(1'b1, 16'h07FD, 2'b11);      endtask
  task automatic term1_w(input logic [7:0] b); send(1'b1, {8'hFD, b}, 2'b10);    endtask
  task automatic stall_w();                    send(1'b0, rnd16(), 2'($urandom_range(0, 3))); endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"},  int'(mac_valid_o), 0);
    check({tag, "_cancel"}, int'(mac_cancel_o), 0);
    check({tag, "_start"},  int'(mac_start_o), 0);
    check({tag, "_term"},   int'(mac_term_o), 0);
    check({tag, "_idle"},   int'(mac_idle_o), 0);
    check({tag, "_ctrlv"},  int'(mac_ctrl_v_o), 0);
    check({tag, "_keep"},   int'(mac_term_keep_o), 0);
    check({tag, "_data"},   int'(mac_data_o), 0);
    check({tag, "_err"},    int'(err_cnt_o), 0);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drain"}, exp_q.size(), 0);
  endtask

  task automatic reset_mid();
    drain("pre_reset");
    nreset = 1'b0;
    xgmii_valid_i = 1'b0;
    #1;
    check_zero("mid_reset");
    model_reset();
    @(negedge clk);
    nreset = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (nreset && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("valid",  int'(mac_valid_o),  int'(e.valid));
        check("cancel", int'(mac_cancel_o), int'(e.cancel));
        check("start",  int'(mac_start_o),  int'(e.start));
        check("term",   int'(mac_term_o),   int'(e.term));
        check("idle",   int'(mac_idle_o),   int'(e.idle));
        check("err",    int'(err_cnt_o),    e.err);
        if (e.valid) begin
          check("data",  int'(mac_data_o),   int'(e.data));
          check("ctrlv", int'(mac_ctrl_v_o), int'(e.ctrl_v));
        end
        if (e.term) check("keep", int'(mac_term_keep_o), int'(e.keep));
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int r;
    int n;
    logic [15:0] d;
    nreset = 1'b1;
    xgmii_valid_i = 1'b0;
    xgmii_data_i = '0;
    xgmii_ctrl_i = '0;
    model_reset();
    #1 nreset = 1'b0;
    @(negedge clk);
    check_zero("reset");
    @(negedge clk);
    nreset = 1'b1;

    // Idle stream
    repeat (5) idle_w();

    // Clean frame: S|0x55, 30 data words, T on lane 0
    start_w(8'h55);
    repeat (30) data_w();
    term0_w();

    // Frame ending with {FD, AB}
    start_w(8'h11);
    repeat (4) data_w();
    term1_w(8'hAB);
    idle_w();

    // Error mid-frame, drop until T, then a clean frame
    start_w(8'h22);
    repeat (3) data_w();
    send(1'b1, {8'h3C, 8'hFE}, 2'b01);
    repeat (3) data_w();
    term0_w();
    start_w(8'h33);
    repeat (2) data_w();
    term0_w();

    // Length overflow: 40 data words, cancel on word 32
    start_w(8'h44);
    repeat (40) data_w();
    term0_w();

    // Exactly MAX_LEN bytes: 1 + 62 + 1
    start_w(8'h66);
    repeat (31) data_w();
    term1_w(8'h77);

    // Stalls mid-frame
    start_w(8'h88);
    repeat (5) data_w();
    repeat (3) stall_w();
    repeat (5) data_w();
    term0_w();

    // Reset mid-frame, then a clean frame
    start_w(8'h99);
    repeat (4) data_w();
    reset_mid();
    start_w(8'hAA);
    repeat (3) data_w();
    term1_w(8'h5A);

    // Randomized frames with stalls, stray ctrl and overflow
    for (int f = 0; f < 25; f++) begin
      n = $urandom_range(0, 36);
      if ($urandom_range(0, 3) == 0) idle_w();
      start_w(8'($urandom_range(0, 255)));
      for (int k = 0; k < n; k++) begin
        r = $urandom_range(0, 99);
        if (r < 8) stall_w();
        else if (r < 10) send(1'b1, rnd16(), 2'($urandom_range(1, 3)));
        else data_w();
      end
      if ($urandom_range(0, 1) == 1) term0_w();
      else term1_w(8'($urandom_range(0, 255)));
    end

    // Unstructured word soup
    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 99);
      d = rnd16();
      if (r < 40) data_w();
      else if (r < 52) idle_w();
      else if (r < 62) start_w(d[15:8]);
      else if (r < 70) term0_w();
      else if (r < 78) term1_w(d[7:0]);
      else if (r < 86) stall_w();
      else send(1'b1, d, 2'($urandom_range(1, 3)));
    end

    send(1'b0, 16'h0000, 2'b00);
    drain("final");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
